hazard_scoreboard: RTL and testbench

- Parametrised decode-stage hazard unit for the WISC pipeline, built on a per-register scoreboard.
- Each architectural register has an age-tracked pending-write entry. Decode is stalled only when a source's producer has not yet reached the stage from which its value can be forwarded.
- Supports a configurable register count, source count, load latency and early (decode-stage) consumers such as branches and jr/jalr.
- Sits beside the decoder. It drives the IF/ID stall and the fetch flush.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bus: decoder-side request fields and stall/flush results.
// The master is the decoder/pipeline control; the slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_W    = 3,
    parameter int unsigned NSRC     = 3,
    parameter int unsigned CNT_W    = 16
);
    logic                    dec_valid;
    logic [NSRC-1:0]         src_valid;
    logic [NSRC*REG_W-1:0]   src_idx;
    logic [NSRC-1:0]         src_early;
    logic                    dst_valid;
    logic [REG_W-1:0]        dst_idx;
    logic                    dst_is_load;
    logic                    ex_stall;
    logic                    redirect;
    logic                    squash;
    logic                    stall_decode;
    logic                    flush_fetch;
    logic [NUM_REGS-1:0]     busy_vec;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output dec_valid, src_valid, src_idx, src_early,
        output dst_valid, dst_idx, dst_is_load,
        output ex_stall, redirect, squash,
        input  stall_decode, flush_fetch, busy_vec, stall_cnt
    );

    modport slave (
        input  dec_valid, src_valid, src_idx, src_early,
        input  dst_valid, dst_idx, dst_is_load,
        input  ex_stall, redirect, squash,
        output stall_decode, flush_fetch, busy_vec, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register age-tracked scoreboard for the WISC decode stage.
// Stalls decode only until a pending producer reaches a forwardable age.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned REG_W       = 3,
    parameter int unsigned NSRC        = 3,
    parameter int unsigned ALU_LAT     = 0,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned EARLY_EXTRA = 2,
    parameter int unsigned RETIRE_AGE  = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned AGE_W = $clog2(RETIRE_AGE + 1);
    localparam int unsigned REQ_W = AGE_W + 1;

    typedef logic [AGE_W-1:0] age_t;
    typedef logic [REQ_W-1:0] req_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] ld_q;
    logic [NUM_REGS-1:0] ld_d;
    age_t                age_q [NUM_REGS];
    age_t                age_d [NUM_REGS];
    cnt_t                stall_cnt_q;

    logic [NSRC-1:0]     src_hit;
    logic                stall;
    logic                issue;

    // Minimum producer age a consumer needs before it can pick up the forwarded value.
    function automatic req_t req_age(input logic is_ld, input logic early);
        req_t base;
        base = is_ld ? req_t'(LOAD_LAT) : req_t'(ALU_LAT);
        return early ? req_t'(base + req_t'(EARLY_EXTRA)) : base;
    endfunction

    // Register matching by loop means out-of-range indices simply never hit.
    always_comb begin
        src_hit = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if ((bus.src_idx[i*REG_W +: REG_W] == REG_W'(r)) && pend_q[r] &&
                    ({1'b0, age_q[r]} < req_age(ld_q[r], bus.src_early[i]))) begin
                    src_hit[i] = bus.src_valid[i];
                end
            end
        end
    end

    assign stall = bus.dec_valid & (|src_hit);
    assign issue = bus.dec_valid & ~stall & ~bus.ex_stall & ~bus.squash;

    always_comb begin
        pend_d = pend_q;
        ld_d   = ld_q;
        age_d  = age_q;
        if (bus.squash) begin
            pend_d = '0;
        end else if (!bus.ex_stall) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (pend_q[r]) begin
                    age_d[r] = age_q[r] + age_t'(1);
                    if (age_q[r] == age_t'(RETIRE_AGE - 1)) begin
                        pend_d[r] = 1'b0;
                    end
                end
            end
            // A new writer restarts the entry, so the youngest producer wins on WAW.
            if (issue && bus.dst_valid) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (bus.dst_idx == REG_W'(r)) begin
                        pend_d[r] = 1'b1;
                        age_d[r]  = '0;
                        ld_d[r]   = bus.dst_is_load;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ld_q   <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                age_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ld_q   <= ld_d;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                age_q[r] <= age_d[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && !bus.squash && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + cnt_t'(1);
        end
    end

    assign bus.stall_decode = stall;
    assign bus.flush_fetch  = bus.redirect;
    assign bus.busy_vec     = pend_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding latencies, ex_stall, WAW, squash, reset.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_scoreboard_if #(.NUM_REGS(8), .REG_W(3), .NSRC(3), .CNT_W(16)) bus ();

    hazard_scoreboard #(
        .NUM_REGS(8), .REG_W(3), .NSRC(3), .ALU_LAT(0), .LOAD_LAT(1),
        .EARLY_EXTRA(2), .RETIRE_AGE(3), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.dec_valid   = 1'b0;
        bus.src_valid   = '0;
        bus.src_idx     = '0;
        bus.src_early   = '0;
        bus.dst_valid   = 1'b0;
        bus.dst_idx     = '0;
        bus.dst_is_load = 1'b0;
        bus.ex_stall    = 1'b0;
        bus.redirect    = 1'b0;
        bus.squash      = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    task automatic producer(input logic [2:0] r, input logic is_ld);
        bus.dec_valid   = 1'b1;
        bus.dst_valid   = 1'b1;
        bus.dst_idx     = r;
        bus.dst_is_load = is_ld;
    endtask

    task automatic consumer(input int s, input logic [2:0] r, input logic early);
        bus.dec_valid        = 1'b1;
        bus.src_valid[s]     = 1'b1;
        bus.src_idx[s*3 +: 3] = r;
        bus.src_early[s]     = early;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.redirect = 1'b1;
        #1;
        chk("init_busy", 32'(bus.busy_vec), 32'h0);
        chk("init_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("init_stall", 32'(bus.stall_decode), 32'h0);
        chk("init_flush", 32'(bus.flush_fetch), 32'h1);

        // ALU -> ALU: no stall, entry busy for three cycles
        next_cycle(); producer(3'd2, 1'b0); #1;
        chk("alu_prod_stall", 32'(bus.stall_decode), 32'h0);
        next_cycle(); consumer(0, 3'd2, 1'b0); #1;
        chk("alu_use_stall", 32'(bus.stall_decode), 32'h0);
        chk("alu_busy1", 32'(bus.busy_vec), 32'h04);
        next_cycle(); #1; chk("alu_busy2", 32'(bus.busy_vec), 32'h04);
        next_cycle(); #1; chk("alu_busy3", 32'(bus.busy_vec), 32'h04);
        next_cycle(); #1; chk("alu_busy_clr", 32'(bus.busy_vec), 32'h00);

        // Load-use: one stall cycle
        next_cycle(); producer(3'd4, 1'b1);
        next_cycle(); consumer(1, 3'd4, 1'b0); #1;
        chk("ld_use_stall", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(1, 3'd4, 1'b0); #1;
        chk("ld_use_go", 32'(bus.stall_decode), 32'h0);
        chk("ld_use_cnt", 32'(bus.stall_cnt), 32'd1);
        idle(3);

        // ALU -> beqz: two stalls
        next_cycle(); producer(3'd1, 1'b0);
        next_cycle(); consumer(0, 3'd1, 1'b1); #1; chk("alu_br_s1", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd1, 1'b1); #1; chk("alu_br_s2", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd1, 1'b1); #1; chk("alu_br_go", 32'(bus.stall_decode), 32'h0);
        chk("alu_br_cnt", 32'(bus.stall_cnt), 32'd3);
        idle(2);

        // Load -> beqz: three stalls
        next_cycle(); producer(3'd3, 1'b1);
        next_cycle(); consumer(0, 3'd3, 1'b1); #1; chk("ld_br_s1", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd3, 1'b1); #1; chk("ld_br_s2", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd3, 1'b1); #1; chk("ld_br_s3", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd3, 1'b1); #1; chk("ld_br_go", 32'(bus.stall_decode), 32'h0);
        chk("ld_br_cnt", 32'(bus.stall_cnt), 32'd6);
        idle(2);

        // jal R7 (redirecting) then jr R7 held under redirect
        next_cycle(); producer(3'd7, 1'b0); bus.redirect = 1'b1; #1;
        chk("jal_flush", 32'(bus.flush_fetch), 32'h1);
        chk("jal_stall", 32'(bus.stall_decode), 32'h0);
        next_cycle(); consumer(0, 3'd7, 1'b1); bus.redirect = 1'b1; #1;
        chk("jr_s1", 32'(bus.stall_decode), 32'h1);
        chk("jr_s1_flush", 32'(bus.flush_fetch), 32'h1);
        next_cycle(); consumer(0, 3'd7, 1'b1); bus.redirect = 1'b1; #1;
        chk("jr_s2", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd7, 1'b1); #1;
        chk("jr_go", 32'(bus.stall_decode), 32'h0);
        chk("jr_noflush", 32'(bus.flush_fetch), 32'h0);
        chk("jr_cnt", 32'(bus.stall_cnt), 32'd8);
        idle(2);

        // ex_stall freezes ages: 4 frozen stalls plus the normal load-use stall
        next_cycle(); producer(3'd5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); consumer(0, 3'd5, 1'b0); bus.ex_stall = 1'b1; #1;
            chk("exs_hold", 32'(bus.stall_decode), 32'h1);
        end
        chk("exs_busy", 32'(bus.busy_vec), 32'h20);
        next_cycle(); consumer(0, 3'd5, 1'b0); #1;
        chk("exs_extra", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd5, 1'b0); #1;
        chk("exs_go", 32'(bus.stall_decode), 32'h0);
        chk("exs_cnt", 32'(bus.stall_cnt), 32'd13);
        idle(3);

        // WAW: ALU rewrite of R6 restarts the entry as a non-load
        next_cycle(); producer(3'd6, 1'b1);
        next_cycle(); producer(3'd6, 1'b0); #1;
        chk("waw_issue", 32'(bus.stall_decode), 32'h0);
        next_cycle(); consumer(0, 3'd6, 1'b0); #1;
        chk("waw_use", 32'(bus.stall_decode), 32'h0);
        next_cycle();
        next_cycle(); #1; chk("waw_busy", 32'(bus.busy_vec), 32'h40);
        next_cycle(); #1; chk("waw_clr", 32'(bus.busy_vec), 32'h00);

        // Squash clears pending entries and does not count as a stall cycle
        next_cycle(); producer(3'd6, 1'b0);
        next_cycle(); consumer(0, 3'd6, 1'b1); #1;
        chk("sq_pre", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd6, 1'b1); bus.squash = 1'b1; #1;
        chk("sq_cyc", 32'(bus.stall_decode), 32'h1);
        next_cycle(); consumer(0, 3'd6, 1'b1); #1;
        chk("sq_busy", 32'(bus.busy_vec), 32'h00);
        chk("sq_go", 32'(bus.stall_decode), 32'h0);
        chk("sq_cnt", 32'(bus.stall_cnt), 32'd14);
        next_cycle(); producer(3'd3, 1'b0); bus.squash = 1'b1; #1;
        next_cycle(); #1;
        chk("sq_no_issue", 32'(bus.busy_vec), 32'h00);

        // Asynchronous reset with R3 pending
        next_cycle(); producer(3'd3, 1'b1);
        next_cycle(); consumer(0, 3'd3, 1'b1); #1;
        chk("rst_pre_busy", 32'(bus.busy_vec), 32'h08);
        chk("rst_pre_stall", 32'(bus.stall_decode), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy_vec), 32'h00);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("rst_stall", 32'(bus.stall_decode), 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_after", 32'(bus.busy_vec), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
